mips_controller: RTL and testbench
==================================

MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, rising edge active.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: op  input  6  instr[31:26] from instruction register.
REQ-004 SHALL have port: funct  input  6  instr[5:0] from instruction register.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have outputs, all 1-bit unless stated:
- iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca
- alusrcb[1:0], pcsrc[1:0], alucont[2:0]
- illegal
- state[3:0], a debug copy of the FSM register.

Function
REQ-007 SHALL be a Moore FSM with registered state[3:0]; all outputs SHALL be combinational decodes of state, plus zero for pcen only.
REQ-008 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12. Codes 13-15 SHALL transition to FETCH.
REQ-009 Transitions SHALL be:
- FETCH->DECODE
- DECODE-> by op: 100011/101011->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 001000->ADDIEX; 000010->JEX; 000101->BNEEX (macro only); any other op->FETCH
- MEMADR->MEMRD if op=100011, else MEMWR
- MEMRD->MEMWB
- RTYPEEX->RTYPEWB
- ADDIEX->ADDIWB
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX -> FETCH
REQ-010 Per-state outputs SHALL be as follows; any output not listed for a state SHALL be 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, alucont=010
- DECODE: alusrcb=11, alucont=010
- MEMADR: alusrca=1, alusrcb=10, alucont=010
- MEMRD: iord=1
- MEMWR: iord=1, memwrite=1
- MEMWB: memtoreg=1, regwrite=1
- RTYPEEX: alusrca=1, alusrcb=00, alucont=funct-decode
- RTYPEWB: regdst=1, regwrite=1
- BEQEX/BNEEX: alusrca=1, alucont=110, pcsrc=01
- ADDIEX: alusrca=1, alusrcb=10, alucont=010
- ADDIWB: regwrite=1
- JEX: pcsrc=10, pcwrite=1
REQ-011 Funct-decode SHALL map 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct SHALL give 010, and illegal=1 during RTYPEEX.
REQ-012 alucont SHALL never be 011 in any state.
REQ-013 pcen SHALL equal pcwrite | (BEQEX & zero) | (BNEEX & ~zero).
REQ-014 illegal SHALL pulse 1 for exactly one cycle in DECODE when op is unsupported; the FSM SHALL then re-enter FETCH, so the PC has already advanced by 4.
REQ-015 Instruction latencies SHALL be: lw 5 cycles; sw, R-type, addi 4; beq, bne, j 3; unsupported op 2.

Reset
REQ-016 reset sampled high at a rising edge SHALL load state=FETCH, including mid-instruction.
REQ-017 While reset is high, irwrite, pcen, regwrite, memwrite and illegal SHALL be forced to 0; all other outputs SHALL follow the state decode.
REQ-018 The first cycle after reset deasserts SHALL be a FETCH with irwrite=1 and pcen=1.

Configuration
REQ-019 Macro BNE_EN SHALL gate the BNE feature:
- Defined: op 000101 SHALL go DECODE->BNEEX, and BNEEX SHALL act per REQ-010 and REQ-013.
- Undefined: op 000101 SHALL be unsupported (illegal pulse, return to FETCH), and the BNEEX code SHALL be unreachable and treated as FETCH-bound.

Verification
REQ-020 Reset held 2 cycles mid-RTYPEEX -> state=0 on the next edge, all write enables 0 while reset is high, then FETCH with irwrite=1 and pcen=1.
REQ-021 op=100011 -> state sequence 0,1,2,3,4,0; memtoreg=1 and regwrite=1 only in state 4; iord=1 in state 3.
REQ-022 op=000000, funct=101010 -> RTYPEEX alucont=111; funct=111111 -> alucont=010 and illegal=1 for one cycle.
REQ-023 op=000100 with zero=1 -> pcen=1 and pcsrc=01 in BEQEX; with zero=0 -> pcen=0; next state FETCH in both cases.
REQ-024 op=000101 with zero=0 and BNE_EN defined -> pcen=1 in BNEEX; same stimulus with BNE_EN undefined -> illegal=1 in DECODE and next state 0.
REQ-025 op=000010 -> states 0,1,11,0 with pcwrite=1 and pcsrc=10 in state 11; op=111111 -> states 0,1,0.

Source files
------------

// File: rtl/mips_controller_if.sv
// Bus bundle for mips_controller: instruction fields and ALU flag in, datapath controls out.
// The controller uses the slave modport; the driver of op/funct/zero uses master.
interface mips_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucont;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output op, funct, zero,
        input  iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucont, illegal, state
    );

    modport slave (
        input  op, funct, zero,
        output iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucont, illegal, state
    );
endinterface

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM (Moore; pcen also depends on zero).
// Define BNE_EN to add the bne instruction (op 000101) via the BNEEX state.
module mips_controller (
    input  logic              clk,
    input  logic              reset,
    mips_controller_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    state_t state_q;
    state_t state_d;

    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucont;
    logic       illegal;
    logic       branch_eq;
    logic       branch_ne;
    logic       funct_bad;

    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef BNE_EN
            OP_BNE: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns {unsupported, alucont}; unknown functs fall back to add so 011 never appears.
    function automatic logic [3:0] funct_decode(input logic [5:0] funct);
        logic [3:0] r;
        case (funct)
            6'b100000: r = 4'b0_010;
            6'b100010: r = 4'b0_110;
            6'b100100: r = 4'b0_000;
            6'b100101: r = 4'b0_001;
            6'b101010: r = 4'b0_111;
            default:   r = 4'b1_010;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        alucont   = 3'b000;
        illegal   = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        funct_bad = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
                alucont = 3'b010;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                alucont = 3'b010;
                illegal = ~op_supported(bus.op);
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alucont = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca              = 1'b1;
                {funct_bad, alucont} = funct_decode(bus.funct);
                illegal              = funct_bad;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca   = 1'b1;
                alucont   = 3'b110;
                pcsrc     = 2'b01;
                branch_eq = 1'b1;
            end
`ifdef BNE_EN
            S_BNEEX: begin
                alusrca   = 1'b1;
                alucont   = 3'b110;
                pcsrc     = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // State-changing enables are held off while reset is asserted.
    assign bus.irwrite  = irwrite & ~reset;
    assign bus.pcen     = (pcwrite | (branch_eq & bus.zero) | (branch_ne & ~bus.zero)) & ~reset;
    assign bus.regwrite = regwrite & ~reset;
    assign bus.memwrite = memwrite & ~reset;
    assign bus.illegal  = illegal & ~reset;
    assign bus.iord     = iord;
    assign bus.regdst   = regdst;
    assign bus.memtoreg = memtoreg;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.alucont  = alucont;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: per-cycle expected outputs from an instruction-level model.
module tb_mips_controller;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_MWR = 5, P_RX = 6,
                   P_RW = 7, P_BEQ = 8, P_AX = 9, P_AW = 10, P_J = 11, P_BNE = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_controller_if bus ();

    mips_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [19:0] exp_q[$];
    int          ph_q[$];

`ifdef BNE_EN
    localparam bit HAS_BNE = 1'b1;
`else
    localparam bit HAS_BNE = 1'b0;
`endif

    // Instruction-level model: the list of control steps an opcode walks through.
    function automatic void steps_for(input logic [5:0] o, output int n, output int s[5]);
        s = '{P_F, P_D, P_F, P_F, P_F};
        n = 2;
        case (o)
            6'b100011: begin s[2] = P_MA; s[3] = P_MR; s[4] = P_MW; n = 5; end
            6'b101011: begin s[2] = P_MA; s[3] = P_MWR; n = 4; end
            6'b000000: begin s[2] = P_RX; s[3] = P_RW; n = 4; end
            6'b001000: begin s[2] = P_AX; s[3] = P_AW; n = 4; end
            6'b000100: begin s[2] = P_BEQ; n = 3; end
            6'b000010: begin s[2] = P_J; n = 3; end
            6'b000101: if (HAS_BNE) begin s[2] = P_BNE; n = 3; end
            default: n = 2;
        endcase
    endfunction

    function automatic logic [19:0] model(input int ph, input logic r, input logic z,
                                          input logic [5:0] o, input logic [5:0] f);
        logic io, mw, ir, pw, pe, rw, rd, mr, sa, ill;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        int n;
        int s[5];
        {io, mw, ir, pw, pe, rw, rd, mr, sa, ill} = '0;
        sb = 2'd0; ps = 2'd0; ac = 3'd0;
        case (ph)
            P_F:   begin ir = 1; pw = 1; sb = 2'b01; ac = 3'b010; end
            P_D:   begin
                sb = 2'b11; ac = 3'b010;
                steps_for(o, n, s);
                ill = (n == 2);
            end
            P_MA, P_AX: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            P_MR:  io = 1;
            P_MWR: begin io = 1; mw = 1; end
            P_MW:  begin mr = 1; rw = 1; end
            P_RX:  begin
                sa = 1;
                case (f)
                    6'b100000: ac = 3'b010;
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default: begin ac = 3'b010; ill = 1; end
                endcase
            end
            P_RW:  begin rd = 1; rw = 1; end
            P_BEQ, P_BNE: begin sa = 1; ac = 3'b110; ps = 2'b01; end
            P_AW:  rw = 1;
            P_J:   begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        pe = pw | (ph == P_BEQ && z) | (ph == P_BNE && !z);
        if (r) begin ir = 0; pe = 0; rw = 0; mw = 0; ill = 0; end
        return {ph[3:0], io, mw, ir, pe, rw, rd, mr, sa, sb, ps, ac, ill};
    endfunction

    // One clock of stimulus: drive inputs after the edge, push the expected outputs.
    task automatic cycle(input int ph, input logic r, input logic [5:0] o,
                         input logic [5:0] f, input int zmode);
        @(posedge clk);
        #1;
        reset     = r;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = (zmode == 2) ? logic'($urandom_range(0, 1)) : logic'(zmode);
        exp_q.push_back(model(ph, r, bus.zero, o, f));
        ph_q.push_back(ph);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode);
        int n;
        int s[5];
        steps_for(o, n, s);
        for (int i = 0; i < n; i++) cycle(s[i], 1'b0, o, f, zmode);
    endtask

    always @(negedge clk) begin
        logic [19:0] act;
        logic [19:0] e;
        int ph;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            ph  = ph_q.pop_front();
            act = {bus.state, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.regwrite,
                   bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc,
                   bus.alucont, bus.illegal};
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL ctrl step=%0d op=%b funct=%b zero=%b reset=%b got=%h expected=%h",
                         ph, bus.op, bus.funct, bus.zero, reset, act, e);
            end
            if (bus.alucont === 3'b011) begin
                fails++;
                $display("FAIL alucont011 got=%b expected=not 011", bus.alucont);
            end
        end
    end

    localparam logic [5:0] OPS [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                       6'b001000, 6'b000010, 6'b000101, 6'b111111};
    localparam logic [5:0] FUNCTS [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                          6'b101010, 6'b111111};

    initial begin
        logic [5:0] o;
        logic [5:0] f;
        reset     = 1'b1;
        bus.op    = 6'd0;
        bus.funct = 6'd0;
        bus.zero  = 1'b0;
        repeat (2) @(posedge clk);
        cycle(P_F, 1'b1, 6'd0, 6'd0, 0);

        run_instr(6'b100011, 6'd0, 2);
        run_instr(6'b000000, 6'b101010, 2);
        run_instr(6'b000000, 6'b111111, 2);
        run_instr(6'b000100, 6'd0, 1);
        run_instr(6'b000100, 6'd0, 0);
        run_instr(6'b000101, 6'd0, 0);
        run_instr(6'b000101, 6'd0, 1);
        run_instr(6'b000010, 6'd0, 2);
        run_instr(6'b111111, 6'd0, 2);
        run_instr(6'b101011, 6'd0, 2);
        run_instr(6'b001000, 6'd0, 2);

        // Reset held for two cycles while in RTYPEEX.
        cycle(P_F,  1'b0, 6'b000000, 6'b100010, 2);
        cycle(P_D,  1'b0, 6'b000000, 6'b100010, 2);
        cycle(P_RX, 1'b1, 6'b000000, 6'b100010, 2);
        cycle(P_F,  1'b1, 6'b000000, 6'b100010, 2);
        run_instr(6'b000000, 6'b100100, 2);

        for (int i = 0; i < 300; i++) begin
            o = OPS[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            f = FUNCTS[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) f = 6'($urandom);
            run_instr(o, f, 2);
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d expected=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
